branch_predict_ctrl: RTL and testbench

- Branch prediction and redirect controller for the 5-stage core.
- In IF, looks up a direct-mapped BTB with 2-bit saturating counters and supplies a predicted next PC.
- In EX, takes the resolved outcome from the branch-condition logic, detects mispredictions, updates the tables, and issues a registered PC redirect plus a timed IF/ID flush window.
- Sits between the PC-select mux and the EX-stage branch comparator.

---
 rtl/branch_predict_ctrl_pkg.sv | 39 +++
 rtl/branch_predict_ctrl_btb_table.sv | 60 ++++++
 rtl/branch_predict_ctrl.sv | 128 ++++++++++++
 tb/tb_branch_predict_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_ctrl_pkg.sv
// Shared branch-kind codes, counter constants and FSM encoding for the predictor.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package branch_predict_ctrl_pkg;

    localparam logic [3:0] B_NONE = 4'd0;
    localparam logic [3:0] BEQ    = 4'd1;
    localparam logic [3:0] BNE    = 4'd2;
    localparam logic [3:0] BLT    = 4'd3;
    localparam logic [3:0] BGE    = 4'd4;
    localparam logic [3:0] BLTU   = 4'd5;
    localparam logic [3:0] BGEU   = 4'd6;
    localparam logic [3:0] BJAL   = 4'd7;
    localparam logic [3:0] BJALR  = 4'd8;

    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;

    typedef enum logic {
        BP_RUN   = 1'b0,
        BP_FLUSH = 1'b1
    } bp_state_e;

    function automatic logic is_cond_br(input logic [3:0] code);
        return (code == BEQ) || (code == BNE) || (code == BLT) ||
               (code == BGE) || (code == BLTU) || (code == BGEU);
    endfunction

    function automatic logic is_jump(input logic [3:0] code);
        return (code == BJAL) || (code == BJALR);
    endfunction

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_btb_table.sv
// Direct-mapped BTB storage: async read port, sync write with counter update, valid clear.
// Latency: read combinational; write visible after the clock edge (reads see old contents).
// Backpressure: none, one write or clear per cycle.
module btb_table
    import branch_predict_ctrl_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_target,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_target,
    input  logic             wr_taken,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx
);
    localparam int ENTRIES = 2 ** IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic               wr_hit;

    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_target = target_q[rd_idx];
    assign rd_ctr    = ctr_q[rd_idx];

    // A tag miss on write means a new owner: its counter restarts from a weak state.
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (wr_en) begin
            valid_q[wr_idx]  <= 1'b1;
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
            ctr_q[wr_idx]    <= wr_hit ? ctr_step(ctr_q[wr_idx], wr_taken)
                                       : (wr_taken ? CTR_WT : CTR_WNT);
        end else if (clr_en) begin
            valid_q[clr_idx] <= 1'b0;
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predictor + redirect controller: BTB lookup in IF, resolve/update/redirect from EX.
// Latency: prediction combinational; redirect and flush registered one cycle after EX resolve.
// Backpressure: none; EX inputs are ignored while the flush window is open.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int IDX_W     = 4,
    parameter int FLUSH_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [3:0]  ex_info_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] mispredict_cnt
);
    localparam int         TAG_W      = 30 - IDX_W;
    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYC - 1);

    bp_state_e        state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             redirect_valid_d, flush_d;
    logic [31:0]      redirect_pc_d, mispredict_cnt_d;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_target;
    logic [1:0]       rd_ctr;
    logic             wr_en, clr_en;

    logic             ex_cond, ex_jump, ex_is_br, ex_eff_taken, ex_mispredict;
    logic [31:0]      ex_actual_next;

    btb_table #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (if_pc[IDX_W+1:2]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_target (rd_target),
        .rd_ctr    (rd_ctr),
        .wr_en     (wr_en),
        .wr_idx    (ex_pc[IDX_W+1:2]),
        .wr_tag    (ex_pc[31:IDX_W+2]),
        .wr_target (ex_target),
        .wr_taken  (ex_eff_taken),
        .clr_en    (clr_en),
        .clr_idx   (ex_pc[IDX_W+1:2])
    );

    assign pred_taken  = rd_valid && (rd_tag == if_pc[31:IDX_W+2]) && rd_ctr[1];
    assign pred_target = pred_taken ? rd_target : if_pc + 32'd4;

    // Jumps always go to their target; non-branches always fall through.
    assign ex_cond        = is_cond_br(ex_info_branch);
    assign ex_jump        = is_jump(ex_info_branch);
    assign ex_is_br       = ex_cond || ex_jump;
    assign ex_eff_taken   = ex_jump || (ex_cond && ex_taken);
    assign ex_actual_next = ex_eff_taken ? ex_target : ex_pc + 32'd4;
    assign ex_mispredict  = (ex_actual_next != ex_pred_target);

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc;
        flush_d          = flush;
        mispredict_cnt_d = mispredict_cnt;
        wr_en            = 1'b0;
        clr_en           = 1'b0;
        case (state_q)
            BP_RUN: begin
                if (ex_valid) begin
                    wr_en  = ex_is_br;
                    clr_en = !ex_is_br && ex_pred_taken;
                    if (ex_mispredict) begin
                        state_d          = BP_FLUSH;
                        cnt_d            = FLUSH_LAST;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = ex_actual_next;
                        flush_d          = 1'b1;
                        mispredict_cnt_d = (mispredict_cnt == 32'hFFFF_FFFF) ? mispredict_cnt
                                                                             : mispredict_cnt + 32'd1;
                    end
                end
            end
            BP_FLUSH: begin
                flush_d = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = BP_RUN;
                    flush_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = BP_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= BP_RUN;
            cnt_q          <= 3'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            flush          <= 1'b0;
            mispredict_cnt <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            flush          <= flush_d;
            mispredict_cnt <= mispredict_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Randomized + directed bench for branch_predict_ctrl with a reference model and scoreboard.
module tb_branch_predict_ctrl;
    import branch_predict_ctrl_pkg::*;

    localparam int IDX_W     = 4;
    localparam int FLUSH_CYC = 2;
    localparam int ENT       = 2 ** IDX_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = 32'd0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic [3:0]  ex_info_branch = 4'd0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = 32'd0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = 32'd0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] mispredict_cnt;

    branch_predict_ctrl #(.IDX_W(IDX_W), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_info_branch (ex_info_branch),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one record per BTB slot, flush window as a count of ignored edges.
    bit          m_valid [ENT];
    logic [31:0] m_tag   [ENT];
    logic [31:0] m_tgt   [ENT];
    int          m_ctr   [ENT];
    int          m_rem;
    logic [31:0] m_cnt;

    typedef struct {
        logic        rv;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        fl;
    } exp_t;
    exp_t exp_q[$];
    bit   mon_en = 1'b0;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % ENT);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = 1;
        end
        m_rem = 0;
        m_cnt = 0;
    endfunction

    function automatic void model_pred(input logic [31:0] pc, output logic t, output logic [31:0] nt);
        int i = slot(pc);
        t  = m_valid[i] && (m_tag[i] == (pc >> (IDX_W + 2))) && (m_ctr[i] >= 2);
        nt = t ? m_tgt[i] : pc + 32'd4;
    endfunction

    // Drive one cycle at a negedge, check the lookup, then advance the model across the edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [3:0] br, input logic tk,
                        input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                        input logic [31:0] ifpc);
        logic        et, cond, jump, taken, hit;
        logic [31:0] ent, actual;
        exp_t        e;
        int          i;
        ex_valid = v; ex_pc = pc; ex_info_branch = br; ex_taken = tk; ex_target = tgt;
        ex_pred_taken = ptk; ex_pred_target = ptgt; if_pc = ifpc;
        #1;
        model_pred(ifpc, et, ent);
        chk("pred_taken", 32'(pred_taken), 32'(et));
        chk("pred_target", pred_target, ent);
        e.rv = 1'b0; e.pc = 32'd0;
        if (m_rem > 0) begin
            m_rem--;
        end else if (v) begin
            cond   = br inside {BEQ, BNE, BLT, BGE, BLTU, BGEU};
            jump   = br inside {BJAL, BJALR};
            taken  = jump || (cond && tk);
            actual = taken ? tgt : pc + 32'd4;
            i      = slot(pc);
            if (cond || jump) begin
                hit = m_valid[i] && (m_tag[i] == (pc >> (IDX_W + 2)));
                if (hit) m_ctr[i] = taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                          : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                else     m_ctr[i] = taken ? 2 : 1;
                m_valid[i] = 1; m_tag[i] = pc >> (IDX_W + 2); m_tgt[i] = tgt;
            end else if (ptk) begin
                m_valid[i] = 0;
            end
            if (actual != ptgt) begin
                m_rem = FLUSH_CYC;
                e.rv  = 1'b1;
                e.pc  = actual;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            end
        end
        e.fl  = (m_rem > 0);
        e.cnt = m_cnt;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] ifpc);
        step(1'b0, 32'd0, B_NONE, 1'b0, 32'd0, 1'b0, 32'd0, ifpc);
    endtask

    // Scoreboard monitor: one expectation per clock edge that the driver issued.
    initial forever begin
        @(posedge clk);
        #1;
        if (mon_en && rst_n) begin
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("flush", 32'(flush), 32'(e.fl));
                chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
                if (e.rv) chk("redirect_pc", redirect_pc, e.pc);
                chk("mispredict_cnt", mispredict_cnt, e.cnt);
            end else if (redirect_valid) begin
                chk("unexpected_redirect", 32'(redirect_valid), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    localparam logic [31:0] POOL [10] = '{32'h100, 32'h140, 32'h200, 32'h240, 32'h300,
                                          32'h40, 32'hFFFF_FFFC, 32'h1100, 32'h10C, 32'h3F8};

    initial begin
        logic        pt;
        logic [31:0] ptg, pc, tgt, ifpc;
        logic [3:0]  br;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_mispredict_cnt", mispredict_cnt, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Cold BEQ: miss, then taken resolve mispredicts to 0x80.
        step(1'b1, 32'h100, BEQ, 1'b1, 32'h80, 1'b0, 32'h104, 32'h100);
        chk("cold_redirect_pc", redirect_pc, 32'h80);
        chk("cold_flush", 32'(flush), 32'd1);
        idle(32'h100);
        idle(32'h100);
        chk("cold_lookup_target", pred_target, 32'h80);

        // Saturation: taken correct predictions, then one not-taken.
        repeat (3) step(1'b1, 32'h100, BEQ, 1'b1, 32'h80, 1'b1, 32'h80, 32'h100);
        step(1'b1, 32'h100, BEQ, 1'b0, 32'h80, 1'b1, 32'h80, 32'h100);
        idle(32'h100);
        idle(32'h100);
        chk("sat_still_taken", 32'(pred_taken), 32'd1);

        // Flush masking: wrong-path BNE during the flush window is ignored.
        step(1'b1, 32'h200, BNE, 1'b1, 32'h280, 1'b0, 32'h204, 32'h200);
        step(1'b1, 32'h140, BNE, 1'b1, 32'h500, 1'b0, 32'h144, 32'h140);
        idle(32'h140);
        idle(32'h140);
        chk("mask_entry_untouched", 32'(pred_taken), 32'd0);
        chk("mask_cnt", mispredict_cnt, 32'd3);

        // Alias: JAL primes 0x40, then a non-branch there invalidates it.
        step(1'b1, 32'h40, BJAL, 1'b0, 32'h400, 1'b0, 32'h44, 32'h40);
        idle(32'h40);
        idle(32'h40);
        step(1'b1, 32'h40, B_NONE, 1'b0, 32'h400, 1'b1, 32'h400, 32'h40);
        idle(32'h40);
        idle(32'h40);
        chk("alias_cleared", 32'(pred_taken), 32'd0);

        // Collision: lookup sees pre-update contents in the writing cycle.
        step(1'b1, 32'h300, BEQ, 1'b1, 32'h380, 1'b0, 32'h304, 32'h300);
        if_pc = 32'h300;
        #1;
        chk("collision_next", 32'(pred_taken), 32'd1);
        idle(32'h300);
        idle(32'h300);

        // Address wrap: 0xFFFFFFFC + 4 = 0.
        step(1'b1, 32'hFFFF_FFFC, B_NONE, 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFC);
        chk("wrap_target", pred_target, 32'h0);
        chk("wrap_no_flush", 32'(flush), 32'd0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            pc   = POOL[$urandom_range(0, 9)];
            br   = 4'($urandom_range(0, 10));
            tgt  = ($urandom_range(0, 1) != 0) ? POOL[$urandom_range(0, 9)] : ($urandom & 32'hFFFF_FFFC);
            ifpc = ($urandom_range(0, 3) == 0) ? pc : POOL[$urandom_range(0, 9)];
            model_pred(pc, pt, ptg);
            if ($urandom_range(0, 3) == 0) begin
                pt  = 1'($urandom_range(0, 1));
                ptg = ($urandom_range(0, 1) != 0) ? pc + 32'd4 : tgt;
            end
            step(1'($urandom_range(0, 3) != 0), pc, br, 1'($urandom_range(0, 1)), tgt, pt, ptg, ifpc);
        end
        repeat (FLUSH_CYC + 1) idle(32'h100);

        // Asynchronous reset during the first flush cycle.
        step(1'b1, 32'h100, BEQ, 1'b1, 32'h88, 1'b0, 32'h104, 32'h100);
        mon_en = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("arst_mispredict_cnt", mispredict_cnt, 32'd0);
        for (int k = 0; k < 10; k++) begin
            if_pc = POOL[k];
            #1;
            chk("arst_lookup_miss", 32'(pred_taken), 32'd0);
        end
        model_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(1'b1, 32'h100, BEQ, 1'b1, 32'h88, 1'b0, 32'h104, 32'h100);
        repeat (FLUSH_CYC + 2) idle(32'h100);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
